// File: rtl/data_path_pkg.sv
// Shared definitions for the RV32I decode/execute slice: opcodes, ALU op codes,
// byte-lane codes and the decoded-instruction record carried through ID/EX.
package data_path_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // alu_op = {f7b5, funct3}
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [3:0] IOB_BYTE = 4'b0001;
    localparam logic [3:0] IOB_HALF = 4'b0011;
    localparam logic [3:0] IOB_WORD = 4'b1111;

    // An all-zero record is a bubble (valid=0, no control asserted).
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic [31:0] imm;
        logic [3:0]  iobytes;
        logic        use_imm;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        store;
        logic        mem_read;
        logic        mem_read_sext;
        logic        regwe;
        logic        lui;
        logic        auipc;
    } dec_t;

    function automatic logic [3:0] iobytes_of(input logic [1:0] size);
        case (size)
            2'b00:   return IOB_BYTE;
            2'b01:   return IOB_HALF;
            2'b10:   return IOB_WORD;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_path_decoder.sv
// Combinational RV32I instruction decoder; unknown opcodes decode as a bubble.
module rv_decoder
    import data_path_pkg::*;
(
    input  logic [31:0] word,
    output dec_t        dec
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd_f;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        has_rd;

    assign opcode = word[6:0];
    assign f3     = word[14:12];
    assign rd_f   = word[11:7];
    assign imm_i  = {{20{word[31]}}, word[31:20]};
    assign imm_s  = {{20{word[31]}}, word[31:25], word[11:7]};
    assign imm_b  = {{19{word[31]}}, word[31], word[7], word[30:25], word[11:8], 1'b0};
    assign imm_u  = {word[31:12], 12'b0};
    assign imm_j  = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};

    always_comb begin
        dec    = '0;
        has_rd = 1'b0;
        case (opcode)
            OP_R: begin
                dec.valid  = 1'b1;
                dec.alu_op = {word[30], f3};
                has_rd     = 1'b1;
            end
            OP_IALU: begin
                dec.valid   = 1'b1;
                dec.alu_op  = {(f3 == 3'b101) & word[30], f3};
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                has_rd      = 1'b1;
            end
            OP_LOAD: begin
                dec.valid         = 1'b1;
                dec.imm           = imm_i;
                dec.use_imm       = 1'b1;
                dec.mem_read      = 1'b1;
                dec.mem_read_sext = ~f3[2];
                dec.iobytes       = iobytes_of(f3[1:0]);
                has_rd            = 1'b1;
            end
            OP_STORE: begin
                dec.valid   = 1'b1;
                dec.imm     = imm_s;
                dec.use_imm = 1'b1;
                dec.store   = 1'b1;
                dec.iobytes = iobytes_of(f3[1:0]);
            end
            OP_BRANCH: begin
                dec.valid  = 1'b1;
                dec.imm    = imm_b;
                dec.branch = 1'b1;
                dec.alu_op = ALU_SUB;
            end
            OP_JAL: begin
                dec.valid = 1'b1;
                dec.imm   = imm_j;
                dec.jal   = 1'b1;
                has_rd    = 1'b1;
            end
            OP_JALR: begin
                dec.valid   = 1'b1;
                dec.imm     = imm_i;
                dec.use_imm = 1'b1;
                dec.jalr    = 1'b1;
                has_rd      = 1'b1;
            end
            OP_LUI: begin
                dec.valid = 1'b1;
                dec.imm   = imm_u;
                dec.lui   = 1'b1;
                has_rd    = 1'b1;
            end
            OP_AUIPC: begin
                dec.valid = 1'b1;
                dec.imm   = imm_u;
                dec.auipc = 1'b1;
                has_rd    = 1'b1;
            end
            default: ;
        endcase
        if (dec.valid) dec.funct3 = f3;
        if (has_rd) dec.rd = rd_f;
        dec.regwe = has_rd && (rd_f != 5'd0);
    end

endmodule

// File: rtl/mux4.sv
// Generic 4:1 multiplexer: sel 00->a, 01->b, 10->c, 11->d.
module mux4 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] y
);

    always_comb begin
        case (sel)
            2'b00:   y = a;
            2'b01:   y = b;
            2'b10:   y = c;
            default: y = d;
        endcase
    end

endmodule

// File: rtl/data_path.sv
// RV32I decode + execute slice: decodes the ID word, holds it in ID/EX and
// computes ALU result, write-back value, pc+imm and branch compare flags.
module data_path
    import data_path_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] id_pc,
    input  logic [31:0]     id_word,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    input  logic [XLEN-1:0] id_rv1,
    input  logic [XLEN-1:0] id_rv2,
    input  logic [1:0]      fwd1_sel,
    input  logic [1:0]      fwd2_sel,
    input  logic [XLEN-1:0] fwd_wb,
    input  logic [XLEN-1:0] fwd_mem,
    output logic [XLEN-1:0] ex_aluout,
    output logic [XLEN-1:0] ex_regwrite,
    output logic [XLEN-1:0] ex_memin,
    output logic [XLEN-1:0] ex_pcimm,
    output logic            ex_z,
    output logic            ex_n,
    output logic            ex_v,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic [3:0]      ex_iobytes,
    output logic            ex_branch,
    output logic            ex_jal,
    output logic            ex_jalr,
    output logic            ex_store,
    output logic            ex_mem_read,
    output logic            ex_mem_read_sext,
    output logic            ex_regwe
);

    dec_t            id_dec, ex_dec;
    logic [XLEN-1:0] ex_pc, ex_rv1, ex_rv2;
    logic [XLEN-1:0] op1, op2, alu_b, alu_res, diff;

    assign id_rs1 = id_word[19:15];
    assign id_rs2 = id_word[24:20];

    rv_decoder u_dec (
        .word (id_word),
        .dec  (id_dec)
    );

    // flush wins over stall so a taken branch always squashes the held slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_dec <= '0;
            ex_pc  <= '0;
            ex_rv1 <= '0;
            ex_rv2 <= '0;
        end else if (flush) begin
            ex_dec <= '0;
            ex_pc  <= '0;
            ex_rv1 <= '0;
            ex_rv2 <= '0;
        end else if (!stall) begin
            ex_dec <= id_dec;
            ex_pc  <= id_pc;
            ex_rv1 <= id_rv1;
            ex_rv2 <= id_rv2;
        end
    end

    mux4 #(.W(XLEN)) u_fwd1 (
        .sel (fwd1_sel), .a(ex_rv1), .b(fwd_wb), .c(fwd_mem), .d(fwd_mem), .y(op1)
    );
    mux4 #(.W(XLEN)) u_fwd2 (
        .sel (fwd2_sel), .a(ex_rv2), .b(fwd_wb), .c(fwd_mem), .d(fwd_mem), .y(op2)
    );

    assign alu_b = ex_dec.use_imm ? ex_dec.imm : op2;
    assign diff  = op1 - op2;

    always_comb begin
        case (ex_dec.alu_op)
            ALU_ADD:  alu_res = op1 + alu_b;
            ALU_SUB:  alu_res = op1 - alu_b;
            ALU_SLL:  alu_res = op1 << alu_b[4:0];
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(alu_b)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < alu_b};
            ALU_XOR:  alu_res = op1 ^ alu_b;
            ALU_SRL:  alu_res = op1 >> alu_b[4:0];
            ALU_SRA:  alu_res = XLEN'($signed(op1) >>> alu_b[4:0]);
            ALU_OR:   alu_res = op1 | alu_b;
            ALU_AND:  alu_res = op1 & alu_b;
            default:  alu_res = op1 + alu_b;
        endcase
    end

    always_comb begin
        ex_aluout = '0;
        ex_n      = 1'b0;
        ex_v      = 1'b0;
        if (ex_dec.valid) begin
            if (ex_dec.branch) ex_aluout = diff;
            else if (ex_dec.jalr) ex_aluout = alu_res & ~XLEN'(1);
            else ex_aluout = alu_res;
        end
        if (ex_dec.valid && ex_dec.branch) begin
            if (ex_dec.funct3[1]) begin
                ex_n = op1 < op2;
            end else begin
                ex_n = diff[XLEN-1];
                ex_v = (op1[XLEN-1] != op2[XLEN-1]) && (diff[XLEN-1] != op1[XLEN-1]);
            end
        end
    end

    assign ex_z     = (ex_aluout == '0);
    assign ex_pcimm = ex_pc + ex_dec.imm;
    assign ex_memin = op2;

    always_comb begin
        if (ex_dec.jal || ex_dec.jalr) ex_regwrite = ex_pc + XLEN'(4);
        else if (ex_dec.lui)           ex_regwrite = ex_dec.imm;
        else if (ex_dec.auipc)         ex_regwrite = ex_pcimm;
        else                           ex_regwrite = ex_aluout;
    end

    assign ex_rd            = ex_dec.rd;
    assign ex_funct3        = ex_dec.funct3;
    assign ex_iobytes       = ex_dec.iobytes;
    assign ex_branch        = ex_dec.branch;
    assign ex_jal           = ex_dec.jal;
    assign ex_jalr          = ex_dec.jalr;
    assign ex_store         = ex_dec.store;
    assign ex_mem_read      = ex_dec.mem_read;
    assign ex_mem_read_sext = ex_dec.mem_read_sext;
    assign ex_regwe         = ex_dec.regwe;

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path with hand-computed expectations.
module tb_data_path;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] id_pc, id_word, id_rv1, id_rv2, fwd_wb, fwd_mem;
    logic [1:0]  fwd1_sel, fwd2_sel;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic [31:0] ex_aluout, ex_regwrite, ex_memin, ex_pcimm;
    logic        ex_z, ex_n, ex_v;
    logic [2:0]  ex_funct3;
    logic [3:0]  ex_iobytes;
    logic        ex_branch, ex_jal, ex_jalr, ex_store, ex_mem_read, ex_mem_read_sext, ex_regwe;

    int n_assert = 0;
    int n_fail   = 0;

    data_path #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_pc(id_pc), .id_word(id_word), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rv1(id_rv1), .id_rv2(id_rv2), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .fwd_wb(fwd_wb), .fwd_mem(fwd_mem), .ex_aluout(ex_aluout), .ex_regwrite(ex_regwrite),
        .ex_memin(ex_memin), .ex_pcimm(ex_pcimm), .ex_z(ex_z), .ex_n(ex_n), .ex_v(ex_v),
        .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_iobytes(ex_iobytes), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_store(ex_store), .ex_mem_read(ex_mem_read),
        .ex_mem_read_sext(ex_mem_read_sext), .ex_regwe(ex_regwe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [31:0] word, input logic [31:0] pc,
                           input logic [31:0] rv1, input logic [31:0] rv2);
        id_word = word;
        id_pc   = pc;
        id_rv1  = rv1;
        id_rv2  = rv2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        fwd1_sel = 2'b00; fwd2_sel = 2'b00; fwd_wb = '0; fwd_mem = '0;
        present(32'h0000_0013, 32'h0, 32'h0, 32'h0);
        #12;
        check("rst_aluout", ex_aluout, 32'h0);
        check("rst_z", {31'b0, ex_z}, 32'h1);
        check("rst_regwe", {31'b0, ex_regwe}, 32'h0);
        check("rst_rd", {27'b0, ex_rd}, 32'h0);
        rst = 1'b0;

        // addi x5,x0,-1
        present(32'hFFF0_0293, 32'h0, 32'h0, 32'h0);
        #1;
        check("addi_rs1", {27'b0, id_rs1}, 32'd0);
        check("addi_rs2", {27'b0, id_rs2}, 32'd31);
        tick();
        check("addi_aluout", ex_aluout, 32'hFFFF_FFFF);
        check("addi_regwe", {31'b0, ex_regwe}, 32'h1);
        check("addi_rd", {27'b0, ex_rd}, 32'd5);

        // sub x3,x1,x2 with op2 forwarded from EX/MEM, then op1 from MEM/WB
        present(32'h4020_81B3, 32'h0, 32'd5, 32'd7);
        #1;
        check("sub_rs1", {27'b0, id_rs1}, 32'd1);
        check("sub_rs2", {27'b0, id_rs2}, 32'd2);
        tick();
        fwd2_sel = 2'b10; fwd_mem = 32'd2;
        #1;
        check("sub_fwdmem", ex_aluout, 32'd3);
        check("sub_memin", ex_memin, 32'd2);
        fwd1_sel = 2'b01; fwd_wb = 32'd9;
        #1;
        check("sub_fwdwb", ex_aluout, 32'd7);
        fwd2_sel = 2'b11;
        #1;
        check("sub_sel11", ex_aluout, 32'd7);
        fwd1_sel = 2'b00; fwd2_sel = 2'b00;

        // blt x1,x2: signed overflow case
        present(32'h0020_C063, 32'h0, 32'h8000_0000, 32'h1);
        tick();
        check("blt_nxorv", {31'b0, ex_n ^ ex_v}, 32'h1);
        check("blt_v", {31'b0, ex_v}, 32'h1);
        check("blt_branch", {31'b0, ex_branch}, 32'h1);
        check("blt_regwe", {31'b0, ex_regwe}, 32'h0);
        check("blt_funct3", {29'b0, ex_funct3}, 32'd4);

        // bltu x1,x2
        present(32'h0020_E063, 32'h0, 32'h1, 32'hFFFF_FFFF);
        tick();
        check("bltu_n", {31'b0, ex_n}, 32'h1);
        check("bltu_v", {31'b0, ex_v}, 32'h0);

        // beq equal
        present(32'h0020_8063, 32'h0, 32'h1234, 32'h1234);
        tick();
        check("beq_z", {31'b0, ex_z}, 32'h1);

        // jal x1,+8 at 0x100
        present(32'h0080_00EF, 32'h100, 32'h0, 32'h0);
        tick();
        check("jal_pcimm", ex_pcimm, 32'h108);
        check("jal_regwrite", ex_regwrite, 32'h104);
        check("jal_flag", {31'b0, ex_jal}, 32'h1);

        // jalr x1,0(x2) at 0x300
        present(32'h0001_00E7, 32'h300, 32'h201, 32'h0);
        tick();
        check("jalr_aluout", ex_aluout, 32'h200);
        check("jalr_regwrite", ex_regwrite, 32'h304);

        // sw x2,4(x1)
        present(32'h0020_A223, 32'h0, 32'h1000, 32'hAB);
        tick();
        check("sw_aluout", ex_aluout, 32'h1004);
        check("sw_memin", ex_memin, 32'hAB);
        check("sw_iobytes", {28'b0, ex_iobytes}, 32'hF);
        check("sw_store", {31'b0, ex_store}, 32'h1);

        // lb x4,0(x1)
        present(32'h0000_8203, 32'h0, 32'h40, 32'h0);
        tick();
        check("lb_iobytes", {28'b0, ex_iobytes}, 32'h1);
        check("lb_read_sext", {30'b0, ex_mem_read, ex_mem_read_sext}, 32'h3);
        check("lb_rd", {27'b0, ex_rd}, 32'd4);

        // srai x6,x1,4
        present(32'h4040_D313, 32'h0, 32'h8000_0000, 32'h0);
        tick();
        check("srai_aluout", ex_aluout, 32'hF800_0000);

        // asynchronous reset mid-run
        rst = 1'b1;
        #1;
        check("arst_regwe", {31'b0, ex_regwe}, 32'h0);
        check("arst_rd", {27'b0, ex_rd}, 32'h0);
        check("arst_aluout", ex_aluout, 32'h0);
        rst = 1'b0;

        // unknown opcode is a bubble
        present(32'h0000_007F, 32'h0, 32'h55, 32'h66);
        tick();
        check("unk_aluout", ex_aluout, 32'h0);
        check("unk_z", {31'b0, ex_z}, 32'h1);

        // lui x7,0x12345 then stall, then flush+stall
        present(32'h1234_53B7, 32'h0, 32'h0, 32'h0);
        tick();
        check("lui_regwrite", ex_regwrite, 32'h1234_5000);
        stall = 1'b1;
        present(32'hFFF0_0293, 32'h0, 32'h0, 32'h0);
        tick();
        check("stall_regwrite", ex_regwrite, 32'h1234_5000);
        check("stall_rd", {27'b0, ex_rd}, 32'd7);
        flush = 1'b1;
        tick();
        check("flush_regwe", {31'b0, ex_regwe}, 32'h0);
        check("flush_rd", {27'b0, ex_rd}, 32'h0);
        check("flush_aluout", ex_aluout, 32'h0);
        check("flush_z", {31'b0, ex_z}, 32'h1);
        flush = 1'b0; stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
